demux_router: RTL and testbench
===============================

DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 Parameter DATA_W, default 136, width of one packed sample word.
REQ-002 Parameter N_OUT, default 4, number of output channels (2..16).
REQ-003 Parameter BURST_LEN, default 64, beats per block in block mode (1..4096).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 mode  in  1  0 = direct select per beat, 1 = block round-robin.
REQ-007 sel  in  $clog2(N_OUT)  target channel in mode 0; start channel after flush in mode 1.
REQ-008 flush  in  1  synchronous clear of block counter and channel pointer.
REQ-009 in_valid / in_ready  in / out  1 each  input handshake.
REQ-010 in_data  in  DATA_W  input sample.
REQ-011 out_valid  out  N_OUT  per-channel valid.
REQ-012 out_ready  in  N_OUT  per-channel ready.
REQ-013 out_data  out  N_OUT*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
REQ-014 cur_ch  out  $clog2(N_OUT)  channel the next accepted beat goes to.
REQ-015 beat_cnt  out  $clog2(BURST_LEN+1)  beats accepted in the current block.
REQ-016 sel_err  out  1  one-cycle pulse when a beat is dropped for an out-of-range select.

Function
REQ-017 Each channel SHALL own one output register (valid bit + data); a beat is transferred on in_valid && in_ready.
REQ-018 Latency SHALL be exactly one cycle: an accepted beat appears on out_data/out_valid of its target channel the next cycle.
REQ-019 in_ready SHALL equal !out_valid[t] || out_ready[t] for target t (combinational pass-through of downstream ready for the target only).
REQ-020 An output register SHALL clear valid on out_valid && out_ready unless refilled in the same cycle; simultaneous drain and fill SHALL keep valid high with new data.
REQ-021 An output channel with valid low SHALL drive all-zero data (idle word).
REQ-022 Mode 0: target = sel each cycle; cur_ch mirrors sel; beat_cnt held at 0.
REQ-023 Mode 0, sel >= N_OUT: in_ready = 1, beat discarded, sel_err pulses for that cycle, no output changes.
REQ-024 Mode 1: target = cur_ch; beat_cnt increments per accepted beat; on the beat making it BURST_LEN, beat_cnt returns to 0 and cur_ch advances by 1, wrapping N_OUT-1 -> 0.
REQ-025 Mode changes SHALL take effect only when beat_cnt == 0; while a block is in progress the active mode is held in an internal register.
REQ-026 flush SHALL set beat_cnt = 0 and cur_ch = sel (0 if out of range) next cycle, leave output registers intact, and block acceptance (in_ready = 0) during the flush cycle.
REQ-027 flush and rst asserted together: rst wins.
REQ-028 No beat SHALL be duplicated or lost except per REQ-023.

Reset
REQ-029 On rst: out_valid = 0, out_data = 0, cur_ch = 0, beat_cnt = 0, sel_err = 0, active mode = 0, in_ready = 0 during the reset cycle.
REQ-030 Reset mid-block SHALL discard the partial block count and all buffered beats.

Structure
REQ-031 A shared package SHALL hold the mode encoding constants (MODE_DIRECT, MODE_BLOCK) and the default DATA_W/N_OUT/BURST_LEN.
REQ-032 The per-channel output register with valid/ready SHALL be a sub-module demux_slot, instantiated N_OUT times via generate.
REQ-033 Channel pointer, beat counter and mode latch SHALL live in the top level.

Verification
REQ-034 Mode 0, N_OUT=4, all out_ready=1, sel=2, in_data=0xA5 one beat -> next cycle out_valid=0100, channel 2 data 0xA5, others zero.
REQ-035 Mode 1, BURST_LEN=4, continuous input 0..15, all ready -> channels 0,1,2,3 each receive 4 beats in order, cur_ch wraps to 0, beat_cnt returns to 0.
REQ-036 Mode 0, out_ready[1]=0, two beats to channel 1 -> first held, in_ready=0 on second until out_ready[1]=1, then second delivered next cycle.
REQ-037 Mode 0, N_OUT=3, sel=3 -> in_ready=1, sel_err pulses once, all out_valid unchanged.
REQ-038 Mode 1, flush after 2 of 4 beats with sel=1 -> beat_cnt=0, cur_ch=1, in_ready=0 for one cycle, next block goes to channel 1.
REQ-039 rst asserted at beat 3 of a block with channel 0 holding data -> all out_valid=0, cur_ch=0, beat_cnt=0 next cycle.

Source files
------------

// File: rtl/demux_router_pkg.sv
// Shared definitions for the demux router: mode encoding and default sizing.
package demux_router_pkg;

    // Routing mode: per-beat direct select, or fixed-length blocks dealt round-robin.
    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_BLOCK  = 1'b1
    } mode_e;

    localparam int DEF_DATA_W    = 136;
    localparam int DEF_N_OUT     = 4;
    localparam int DEF_BURST_LEN = 64;

endpackage

// File: rtl/demux_slot.sv
// One output channel register: a single valid bit plus data word.
// Handshake: a word moves downstream when out_valid && out_ready are both high
// in the same cycle; the slot can take a new word (slot_ready) when it is empty
// or being drained this cycle.
module demux_slot
    import demux_router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              slot_ready
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // Slot can accept when empty or when the current word leaves this cycle.
    always_comb begin
        slot_ready = !valid_q || out_ready;
        out_valid  = valid_q;
        out_data   = data_q;
    end

    // Fill has priority over drain so a simultaneous drain+fill keeps valid high;
    // an emptied slot returns to the all-zero idle word.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (fill) begin
            valid_q <= 1'b1;
            data_q  <= fill_data;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end
    end

endmodule

// File: rtl/demux_router.sv
// Demultiplexing router: steers each accepted input beat to one of N_OUT
// output slots, either by direct select or in round-robin blocks of BURST_LEN.
// Input handshake: a beat transfers when in_valid && in_ready; in_ready follows
// only the target slot's readiness and is low during reset and flush.
module demux_router
    import demux_router_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int N_OUT     = DEF_N_OUT,
    parameter  int BURST_LEN = DEF_BURST_LEN,
    localparam int SEL_W     = $clog2(N_OUT),
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]        cur_ch,
    output logic [CNT_W-1:0]        beat_cnt,
    output logic                    sel_err
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(N_OUT - 1);

    mode_e             mode_lat;
    mode_e             eff_mode;
    logic [SEL_W-1:0]  ch_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [SEL_W-1:0]  tgt;
    logic              sel_oor;
    logic              sel_in_range;
    logic              tgt_ready;
    logic              accept;
    logic [N_OUT-1:0]  slot_ready;
    logic [N_OUT-1:0]  fill;

    // Target selection, input handshake and per-slot fill strobes.
    always_comb begin
        eff_mode     = (cnt == '0) ? mode_e'(mode) : mode_lat;
        sel_in_range = int'(sel) < N_OUT;
        sel_oor      = (eff_mode == MODE_DIRECT) && !sel_in_range;
        tgt          = (eff_mode == MODE_BLOCK) ? ch_ptr : sel;
        tgt_ready    = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (int'(tgt) == k) tgt_ready = slot_ready[k];
        end
        in_ready = !rst && !flush && (sel_oor || tgt_ready);
        accept   = in_valid && in_ready;
        sel_err  = accept && sel_oor;
        for (int k = 0; k < N_OUT; k++) begin
            fill[k] = accept && !sel_oor && (int'(tgt) == k);
        end
        cur_ch   = rst ? '0 : tgt;
        beat_cnt = cnt;
    end

    // Channel pointer, beat counter and mode latch; a block in progress pins the mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_lat <= MODE_DIRECT;
            cnt      <= '0;
            ch_ptr   <= '0;
        end else if (flush) begin
            mode_lat <= eff_mode;
            cnt      <= '0;
            ch_ptr   <= sel_in_range ? sel : '0;
        end else begin
            mode_lat <= eff_mode;
            if (accept && eff_mode == MODE_BLOCK) begin
                if (cnt == LAST_BEAT) begin
                    cnt    <= '0;
                    ch_ptr <= (ch_ptr == LAST_CH) ? '0 : ch_ptr + SEL_W'(1);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .fill      (fill[k]),
            .fill_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W]),
            .slot_ready(slot_ready[k])
        );
    end

endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router: a 4-channel instance for routing, block and
// flush behaviour, and a 3-channel instance for the out-of-range select case.
module tb_demux_router;

    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        flush;
    logic        in_valid;
    logic [1:0]  sel;
    logic [15:0] in_data;
    logic [3:0]  out_ready;
    logic [2:0]  b_out_ready;

    logic        in_ready;
    logic [3:0]  out_valid;
    logic [63:0] out_data;
    logic [1:0]  cur_ch;
    logic [2:0]  beat_cnt;
    logic        sel_err;

    logic        b_in_ready;
    logic [2:0]  b_out_valid;
    logic [47:0] b_out_data;
    logic [1:0]  b_cur_ch;
    logic [2:0]  b_beat_cnt;
    logic        b_sel_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [15:0] d;
        logic        rdy;
        logic [3:0]  ov;
        logic [63:0] od;
    } vec_t;

    vec_t vecs[5];

    demux_router #(.DATA_W(DW), .N_OUT(4), .BURST_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cur_ch(cur_ch), .beat_cnt(beat_cnt), .sel_err(sel_err)
    );

    demux_router #(.DATA_W(DW), .N_OUT(3), .BURST_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .cur_ch(b_cur_ch), .beat_cnt(b_beat_cnt), .sel_err(b_sel_err)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] tmp;
        logic [15:0] got;
        int          ch;

        vecs[0] = '{1'b1, 2'd2, 16'h00A5, 1'b1, 4'b0100, 64'h0000_00A5_0000_0000};
        vecs[1] = '{1'b1, 2'd0, 16'h1234, 1'b1, 4'b0001, 64'h0000_0000_0000_1234};
        vecs[2] = '{1'b1, 2'd3, 16'hBEEF, 1'b1, 4'b1000, 64'hBEEF_0000_0000_0000};
        vecs[3] = '{1'b0, 2'd1, 16'hFFFF, 1'b1, 4'b0000, 64'h0000_0000_0000_0000};
        vecs[4] = '{1'b1, 2'd1, 16'h5A5A, 1'b1, 4'b0010, 64'h0000_0000_5A5A_0000};

        rst = 1'b1; mode = 1'b1; flush = 1'b0; in_valid = 1'b1; sel = 2'd2;
        in_data = 16'h0; out_ready = 4'hF; b_out_ready = 3'b111;

        // Reset state
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_sel_err", 64'(sel_err), 64'd0);
        chk("rst_cur_ch", 64'(cur_ch), 64'd0);
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        rst = 1'b0; in_valid = 1'b0; mode = 1'b0;

        // Direct mode vector table
        for (int i = 0; i < 5; i++) begin
            in_valid  = vecs[i].v;
            sel       = vecs[i].sel;
            in_data   = vecs[i].d;
            out_ready = 4'hF;
            #1;
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].rdy));
            chk($sformatf("v%0d_cur_ch", i), 64'(cur_ch), 64'(vecs[i].sel));
            chk($sformatf("v%0d_beat_cnt", i), 64'(beat_cnt), 64'd0);
            tick();
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].od);
        end
        in_valid = 1'b0;
        tick();

        // Backpressure on channel 1
        out_ready = 4'b1101; sel = 2'd1; in_valid = 1'b1; in_data = 16'h1111;
        #1;
        chk("bp_first_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp_first_valid", 64'(out_valid), 64'b0010);
        chk("bp_first_data", out_data, 64'h0000_0000_1111_0000);
        in_data = 16'h2222;
        #1;
        chk("bp_stall_ready0", 64'(in_ready), 64'd0);
        tick();
        #1;
        chk("bp_stall_ready1", 64'(in_ready), 64'd0);
        tick();
        chk("bp_hold_data", out_data, 64'h0000_0000_1111_0000);
        out_ready = 4'hF;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp_second_valid", 64'(out_valid), 64'b0010);
        chk("bp_second_data", out_data, 64'h0000_0000_2222_0000);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Out-of-range select on the 3-channel instance
        b_out_ready = 3'b110; sel = 2'd0; in_valid = 1'b1; in_data = 16'h0077;
        tick();
        chk("oor_pre_valid", 64'(b_out_valid), 64'b001);
        sel = 2'd3; in_data = 16'hDEAD;
        #1;
        chk("oor_in_ready", 64'(b_in_ready), 64'd1);
        chk("oor_sel_err", 64'(b_sel_err), 64'd1);
        tick();
        chk("oor_valid_kept", 64'(b_out_valid), 64'b001);
        chk("oor_data_kept", 64'(b_out_data), 64'h0077);
        in_valid = 1'b0;
        #1;
        chk("oor_err_cleared", 64'(b_sel_err), 64'd0);
        b_out_ready = 3'b111;
        tick();

        // Block mode: 16 beats round-robin over 4 channels
        do_reset();
        mode = 1'b1; out_ready = 4'hF; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 16'(i);
            #1;
            chk($sformatf("blk%0d_cur_ch", i), 64'(cur_ch), 64'(i / 4));
            chk($sformatf("blk%0d_beat_cnt", i), 64'(beat_cnt), 64'(i % 4));
            chk($sformatf("blk%0d_in_ready", i), 64'(in_ready), 64'd1);
            if (in_ready) exp_q.push_back(in_data);
            tick();
            ch  = i / 4;
            tmp = 64'd1 << ch;
            chk($sformatf("blk%0d_out_valid", i), 64'(out_valid), tmp);
            got = out_data[ch*DW +: DW];
            if (exp_q.size() == 0) begin
                chk($sformatf("blk%0d_queue_empty", i), 64'd1, 64'd0);
            end else begin
                chk($sformatf("blk%0d_data", i), 64'(got), 64'(exp_q.pop_front()));
            end
        end
        in_valid = 1'b0;
        #1;
        chk("blk_end_cur_ch", 64'(cur_ch), 64'd0);
        chk("blk_end_beat_cnt", 64'(beat_cnt), 64'd0);
        tick();

        // Mode change mid-block is deferred until the block completes
        do_reset();
        mode = 1'b1; in_valid = 1'b1; in_data = 16'h0021;
        tick();
        mode = 1'b0; sel = 2'd3; in_data = 16'h0022;
        #1;
        chk("hold_cur_ch", 64'(cur_ch), 64'd0);
        chk("hold_beat_cnt", 64'(beat_cnt), 64'd1);
        tick();
        chk("hold_out_valid", 64'(out_valid), 64'b0001);
        chk("hold_out_data", out_data, 64'h0000_0000_0000_0022);
        chk("hold_beat_cnt2", 64'(beat_cnt), 64'd2);
        in_valid = 1'b0; mode = 1'b1;
        tick();

        // Flush after two beats of a block
        do_reset();
        mode = 1'b1; out_ready = 4'hF; in_valid = 1'b1; in_data = 16'h0010;
        tick();
        in_data = 16'h0011;
        tick();
        chk("fl_pre_valid", 64'(out_valid), 64'b0001);
        chk("fl_pre_beat_cnt", 64'(beat_cnt), 64'd2);
        flush = 1'b1; sel = 2'd1; out_ready = 4'h0; in_data = 16'h0012;
        #1;
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; out_ready = 4'hF; in_data = 16'h0030;
        #1;
        chk("fl_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("fl_cur_ch", 64'(cur_ch), 64'd1);
        chk("fl_outputs_intact", out_data, 64'h0000_0000_0000_0011);
        chk("fl_post_ready", 64'(in_ready), 64'd1);
        for (int j = 0; j < 4; j++) begin
            in_data = 16'(16'h0030 + j);
            tick();
            chk($sformatf("fl_blk%0d_valid", j), 64'(out_valid), 64'b0010);
            chk($sformatf("fl_blk%0d_data", j), out_data, 64'(16'h0030 + j) << 16);
        end
        in_valid = 1'b0;
        #1;
        chk("fl_end_cur_ch", 64'(cur_ch), 64'd2);
        chk("fl_end_beat_cnt", 64'(beat_cnt), 64'd0);
        tick();

        // Reset in the middle of a block
        do_reset();
        mode = 1'b1; out_ready = 4'hF; in_valid = 1'b1; in_data = 16'h0040;
        tick();
        in_data = 16'h0041;
        tick();
        chk("mr_pre_valid", 64'(out_valid), 64'b0001);
        chk("mr_pre_data", out_data, 64'h0000_0000_0000_0041);
        rst = 1'b1; in_data = 16'h0042;
        #1;
        chk("mr_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_out_data", out_data, 64'd0);
        chk("mr_cur_ch", 64'(cur_ch), 64'd0);
        chk("mr_beat_cnt", 64'(beat_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
